// File: rtl/id_ex_pipe.sv
// ID->EXE pipeline register: 1-cycle latency, optional 2-entry skid buffer (SKID=1) with registered in_ready.
// Backpressure: holds entries while out_ready=0; flush drops everything and reopens in_ready next cycle.
module id_ex_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUC_W     = 4,
  parameter int SKID       = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  write_reg,
  input  logic                  mem_to_reg,
  input  logic                  write_mem,
  input  logic                  shift,
  input  logic                  alu_imm,
  input  logic [ALUC_W-1:0]     aluc,
  input  logic [DATA_W-1:0]     operand_1_i,
  input  logic [DATA_W-1:0]     operand_2_i,
  input  logic [DATA_W-1:0]     operand_imm_i,
  input  logic [REG_ADDR_W-1:0] des_r_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  exe_write_reg,
  output logic                  exe_mem_to_reg,
  output logic                  exe_write_mem,
  output logic                  exe_shift,
  output logic                  exe_alu_imm,
  output logic [ALUC_W-1:0]     exe_aluc,
  output logic [DATA_W-1:0]     operand_1_o,
  output logic [DATA_W-1:0]     operand_2_o,
  output logic [DATA_W-1:0]     operand_imm_o,
  output logic [REG_ADDR_W-1:0] des_r_o,
  output logic [CNT_W-1:0]      bubble_count
);

  typedef struct packed {
    logic                  write_reg;
    logic                  mem_to_reg;
    logic                  write_mem;
    logic                  shift;
    logic                  alu_imm;
    logic [ALUC_W-1:0]     aluc;
    logic [DATA_W-1:0]     op1;
    logic [DATA_W-1:0]     op2;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] des_r;
  } ex_dat_t;

  typedef enum logic [1:0] {EMPTY, FULL, SKIDDED} state_t;

  state_t  state_q;
  ex_dat_t in_dat, main_q, skid_q;
  logic    rdy_q;
  logic    accept, consume;

  always_comb begin
    in_dat            = '0;
    in_dat.write_reg  = write_reg;
    in_dat.mem_to_reg = mem_to_reg;
    in_dat.write_mem  = write_mem;
    in_dat.shift      = shift;
    in_dat.alu_imm    = alu_imm;
    in_dat.aluc       = aluc;
    in_dat.op1        = operand_1_i;
    in_dat.op2        = operand_2_i;
    in_dat.imm        = operand_imm_i;
    in_dat.des_r      = des_r_i;
  end

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (SKID != 0) ? rdy_q : (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  // SKIDDED is only reachable with SKID=1: with SKID=0 an accept in FULL implies a consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else if (flush) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q  <= in_dat;
            state_q <= FULL;
          end
        end
        FULL: begin
          if (accept && consume) begin
            main_q <= in_dat;
          end else if (accept) begin
            skid_q  <= in_dat;
            state_q <= SKIDDED;
            rdy_q   <= 1'b0;
          end else if (consume) begin
            state_q <= EMPTY;
          end
        end
        SKIDDED: begin
          if (consume) begin
            main_q  <= skid_q;
            state_q <= FULL;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (out_ready && !out_valid && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

  // Write enables are masked so a drained or flushed stage never commits side effects.
  assign exe_write_reg  = main_q.write_reg & out_valid;
  assign exe_write_mem  = main_q.write_mem & out_valid;
  assign exe_mem_to_reg = main_q.mem_to_reg;
  assign exe_shift      = main_q.shift;
  assign exe_alu_imm    = main_q.alu_imm;
  assign exe_aluc       = main_q.aluc;
  assign operand_1_o    = main_q.op1;
  assign operand_2_o    = main_q.op2;
  assign operand_imm_o  = main_q.imm;
  assign des_r_o        = main_q.des_r;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench: u0 default build, u1 with CNT_W=2 for saturation, u2 with SKID=0.
module tb_id_ex_pipe;

  logic clk = 1'b0;
  logic rst, in_valid, flush, out_ready;
  logic write_reg, mem_to_reg, write_mem, shift, alu_imm;
  logic [3:0]  aluc;
  logic [31:0] op1, op2, imm;
  logic [4:0]  des_r;

  logic [2:0]  ov, ir, ewr, emr, ewm, esh, eai;
  logic [3:0]  aluc_o [3];
  logic [31:0] op1_o [3];
  logic [31:0] op2_o [3];
  logic [31:0] imm_o [3];
  logic [4:0]  des_o [3];
  logic [15:0] bc0, bc2;
  logic [1:0]  bc1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_pipe u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .flush(flush),
    .write_reg(write_reg), .mem_to_reg(mem_to_reg), .write_mem(write_mem), .shift(shift), .alu_imm(alu_imm),
    .aluc(aluc), .operand_1_i(op1), .operand_2_i(op2), .operand_imm_i(imm), .des_r_i(des_r),
    .out_valid(ov[0]), .out_ready(out_ready),
    .exe_write_reg(ewr[0]), .exe_mem_to_reg(emr[0]), .exe_write_mem(ewm[0]), .exe_shift(esh[0]), .exe_alu_imm(eai[0]),
    .exe_aluc(aluc_o[0]), .operand_1_o(op1_o[0]), .operand_2_o(op2_o[0]), .operand_imm_o(imm_o[0]), .des_r_o(des_o[0]),
    .bubble_count(bc0)
  );

  id_ex_pipe #(.CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .flush(flush),
    .write_reg(write_reg), .mem_to_reg(mem_to_reg), .write_mem(write_mem), .shift(shift), .alu_imm(alu_imm),
    .aluc(aluc), .operand_1_i(op1), .operand_2_i(op2), .operand_imm_i(imm), .des_r_i(des_r),
    .out_valid(ov[1]), .out_ready(out_ready),
    .exe_write_reg(ewr[1]), .exe_mem_to_reg(emr[1]), .exe_write_mem(ewm[1]), .exe_shift(esh[1]), .exe_alu_imm(eai[1]),
    .exe_aluc(aluc_o[1]), .operand_1_o(op1_o[1]), .operand_2_o(op2_o[1]), .operand_imm_o(imm_o[1]), .des_r_o(des_o[1]),
    .bubble_count(bc1)
  );

  id_ex_pipe #(.SKID(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .flush(flush),
    .write_reg(write_reg), .mem_to_reg(mem_to_reg), .write_mem(write_mem), .shift(shift), .alu_imm(alu_imm),
    .aluc(aluc), .operand_1_i(op1), .operand_2_i(op2), .operand_imm_i(imm), .des_r_i(des_r),
    .out_valid(ov[2]), .out_ready(out_ready),
    .exe_write_reg(ewr[2]), .exe_mem_to_reg(emr[2]), .exe_write_mem(ewm[2]), .exe_shift(esh[2]), .exe_alu_imm(eai[2]),
    .exe_aluc(aluc_o[2]), .operand_1_o(op1_o[2]), .operand_2_o(op2_o[2]), .operand_imm_o(imm_o[2]), .des_r_o(des_o[2]),
    .bubble_count(bc2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; out_ready = 0;
    write_reg = 0; mem_to_reg = 0; write_mem = 0; shift = 0; alu_imm = 0;
    aluc = 4'h0; op1 = 0; op2 = 0; imm = 0; des_r = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step();
    total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", ov[0]); end
    total++; if (ir[0] !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", ir[0]); end
    total++; if (bc0 !== 16'd0) begin bad++; $display("FAIL reset_bubble got=%0d exp=0", bc0); end
    total++; if ({ewr[0], ewm[0], emr[0], op1_o[0], des_o[0]} !== '0) begin bad++; $display("FAIL reset_outputs got=%0h exp=0", {ewr[0], ewm[0], emr[0], op1_o[0], des_o[0]}); end
    rst = 0;
  endtask

  task automatic test_bubble();
    do_reset();
    out_ready = 1;
    repeat (5) step();
    total++; if (bc0 !== 16'd5) begin bad++; $display("FAIL bubble5 got=%0d exp=5", bc0); end
    step();
    total++; if (bc0 !== 16'd6) begin bad++; $display("FAIL bubble6 got=%0d exp=6", bc0); end
    total++; if (bc1 !== 2'd3) begin bad++; $display("FAIL bubble_sat got=%0d exp=3", bc1); end
  endtask

  task automatic test_stream();
    do_reset();
    in_valid = 1; out_ready = 1; write_reg = 1; des_r = 5'd7;
    for (int i = 1; i <= 3; i++) begin
      op1 = i;
      step();
      total++; if (op1_o[0] !== 32'(i)) begin bad++; $display("FAIL stream_op1_%0d got=%0h exp=%0h", i, op1_o[0], i); end
      total++; if ({ov[0], ir[0], ewr[0]} !== 3'b111) begin bad++; $display("FAIL stream_flags_%0d got=%b exp=111", i, {ov[0], ir[0], ewr[0]}); end
    end
    total++; if (des_o[0] !== 5'd7) begin bad++; $display("FAIL stream_des got=%0d exp=7", des_o[0]); end
    in_valid = 0;
    step();
    total++; if ({ov[0], ewr[0], op1_o[0]} !== {2'b00, 32'd3}) begin bad++; $display("FAIL stream_drain got=%0h exp=3", {ov[0], ewr[0], op1_o[0]}); end
  endtask

  task automatic test_stall();
    do_reset();
    in_valid = 1; op1 = 32'hA;
    step();
    total++; if ({ov[0], ir[0], op1_o[0]} !== {2'b11, 32'hA}) begin bad++; $display("FAIL stall_full got=%0h exp=%0h", {ov[0], ir[0], op1_o[0]}, {2'b11, 32'hA}); end
    op1 = 32'hB;
    step();
    total++; if ({ov[0], ir[0], op1_o[0]} !== {2'b10, 32'hA}) begin bad++; $display("FAIL stall_skid got=%0h exp=%0h", {ov[0], ir[0], op1_o[0]}, {2'b10, 32'hA}); end
    op1 = 32'hD;
    step();
    total++; if ({ov[0], ir[0], op1_o[0]} !== {2'b10, 32'hA}) begin bad++; $display("FAIL stall_hold got=%0h exp=%0h", {ov[0], ir[0], op1_o[0]}, {2'b10, 32'hA}); end
    in_valid = 0; out_ready = 1;
    step();
    total++; if ({ov[0], ir[0], op1_o[0]} !== {2'b11, 32'hB}) begin bad++; $display("FAIL stall_drain_b got=%0h exp=%0h", {ov[0], ir[0], op1_o[0]}, {2'b11, 32'hB}); end
    step();
    total++; if ({ov[0], ir[0]} !== 2'b01) begin bad++; $display("FAIL stall_empty got=%b exp=01", {ov[0], ir[0]}); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1;
    repeat (2) step();
    out_ready = 0; in_valid = 1; write_reg = 1; write_mem = 1; op1 = 32'hA;
    step();
    op1 = 32'hB;
    step();
    flush = 1; op1 = 32'hC;
    step();
    flush = 0; in_valid = 0;
    total++; if ({ov[0], ewr[0], ewm[0], ir[0]} !== 4'b0001) begin bad++; $display("FAIL flush_state got=%b exp=0001", {ov[0], ewr[0], ewm[0], ir[0]}); end
    total++; if (bc0 !== 16'd2) begin bad++; $display("FAIL flush_keeps_bubble got=%0d exp=2", bc0); end
    out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL flush_no_c_%0d got=%0b exp=0", i, ov[0]); end
    end
    total++; if (bc0 !== 16'd4) begin bad++; $display("FAIL flush_bubble_after got=%0d exp=4", bc0); end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1; write_mem = 1; op1 = 32'h11;
    step();
    in_valid = 0;
    total++; if ({ov[0], ewm[0]} !== 2'b11) begin bad++; $display("FAIL areset_pre got=%b exp=11", {ov[0], ewm[0]}); end
    #2 rst = 1;
    #1;
    total++; if ({ov[0], ewm[0], ir[0]} !== 3'b001) begin bad++; $display("FAIL areset_mid got=%b exp=001", {ov[0], ewm[0], ir[0]}); end
    #1 rst = 0;
    in_valid = 1; write_mem = 0; op1 = 32'h55;
    step();
    in_valid = 0;
    total++; if ({ov[0], ir[0], op1_o[0]} !== {2'b11, 32'h55}) begin bad++; $display("FAIL areset_post got=%0h exp=%0h", {ov[0], ir[0], op1_o[0]}, {2'b11, 32'h55}); end
  endtask

  task automatic test_skid0();
    do_reset();
    in_valid = 1; op1 = 32'h1;
    step();
    total++; if ({ov[2], ir[2]} !== 2'b10) begin bad++; $display("FAIL skid0_stall got=%b exp=10", {ov[2], ir[2]}); end
    out_ready = 1;
    #1;
    total++; if (ir[2] !== 1'b1) begin bad++; $display("FAIL skid0_ready_comb got=%0b exp=1", ir[2]); end
    for (int i = 2; i <= 3; i++) begin
      op1 = i;
      step();
      total++; if ({ov[2], op1_o[2]} !== {1'b1, 32'(i)}) begin bad++; $display("FAIL skid0_b2b_%0d got=%0h exp=%0h", i, {ov[2], op1_o[2]}, {1'b1, 32'(i)}); end
    end
    in_valid = 0; out_ready = 0;
    step();
    total++; if ({ov[2], ir[2], op1_o[2]} !== {2'b10, 32'h3}) begin bad++; $display("FAIL skid0_hold got=%0h exp=%0h", {ov[2], ir[2], op1_o[2]}, {2'b10, 32'h3}); end
  endtask

  initial begin
    test_reset();
    test_bubble();
    test_stream();
    test_stall();
    test_flush();
    test_async_reset();
    test_skid0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
